// File: rtl/truth_table_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tt_state_e;

  function automatic int calc_n_vec(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int calc_tbl_w(input int n_in, input int n_out);
    return n_out * calc_n_vec(n_in);
  endfunction

endpackage

// File: rtl/tt_vector_counter.sv
// Walks the vector index, holding each index for DWELL cycles while running.
module tt_vector_counter #(
  parameter int N_IN  = 4,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_run,
  output logic [N_IN-1:0] o_idx,
  output logic            o_sample,
  output logic            o_last
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0] r_dwell_cnt;
  logic [N_IN-1:0] r_idx;

  assign o_idx    = r_idx;
  assign o_sample = i_run && (r_dwell_cnt == DW_LAST);
  assign o_last   = (r_idx == {N_IN{1'b1}});

  // Counters park at zero whenever the sweep is not running, so a new
  // sweep always starts from vector 0 with a fresh dwell window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell_cnt <= '0;
      r_idx       <= '0;
    end else if (!i_run) begin
      r_dwell_cnt <= '0;
      r_idx       <= '0;
    end else if (o_sample) begin
      r_dwell_cnt <= '0;
      r_idx       <= r_idx + 1'b1;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input codes, captures the response table and counts mismatches.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int DWELL = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [calc_tbl_w(N_IN, N_OUT)-1:0]  expected,
  output logic [N_IN-1:0]                     stim,
  input  logic [N_OUT-1:0]                    resp,
  output logic                                busy,
  output logic                                done,
  output logic [calc_tbl_w(N_IN, N_OUT)-1:0]  captured,
  output logic [N_IN:0]                       err_count,
  output logic                                err_valid,
  output logic [N_IN-1:0]                     first_err_idx
);

  localparam int N_VEC = calc_n_vec(N_IN);
  localparam int TBL_W = calc_tbl_w(N_IN, N_OUT);

  tt_state_e        r_state;
  logic             r_busy;
  logic             r_done;
  logic [TBL_W-1:0] r_exp;
  logic [TBL_W-1:0] r_captured;
  logic [N_IN:0]    r_err_count;
  logic             r_err_valid;
  logic [N_IN-1:0]  r_first_err;

  logic [N_IN-1:0]  w_idx;
  logic             w_sample;
  logic             w_last;
  logic             w_run;
  logic [N_OUT-1:0] w_exp_bits;
  logic             w_mismatch;

  assign w_run = (r_state == ST_RUN);

  tt_vector_counter #(
    .N_IN  (N_IN),
    .DWELL (DWELL)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .o_idx    (w_idx),
    .o_sample (w_sample),
    .o_last   (w_last)
  );

  always_comb begin
    w_exp_bits = '0;
    for (int k = 0; k < N_OUT; k++) begin
      w_exp_bits[k] = r_exp[k*N_VEC + int'(w_idx)];
    end
  end

  assign w_mismatch = |(w_exp_bits ^ resp);

  // The counter index lingers for one cycle after an abort, so gate it.
  assign stim          = w_run ? w_idx : '0;
  assign busy          = r_busy;
  assign done          = r_done;
  assign captured      = r_captured;
  assign err_count     = r_err_count;
  assign err_valid     = r_err_valid;
  assign first_err_idx = r_first_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_exp       <= '0;
      r_captured  <= '0;
      r_err_count <= '0;
      r_err_valid <= 1'b0;
      r_first_err <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_exp       <= expected;
            r_captured  <= '0;
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_first_err <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_sample) begin
            for (int k = 0; k < N_OUT; k++) begin
              r_captured[k*N_VEC + int'(w_idx)] <= resp[k];
            end
            if (w_mismatch) begin
              r_err_count <= r_err_count + 1'b1;
              if (!r_err_valid) begin
                r_err_valid <= 1'b1;
                r_first_err <= w_idx;
              end
            end
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a DWELL=1 and a DWELL=3 instance.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        start1, start3;
  logic [15:0] expected;

  logic [3:0]  stim1, stim3;
  logic [0:0]  resp1, resp3;
  logic        busy1, busy3, done1, done3;
  logic [15:0] captured1, captured3;
  logic [4:0]  err_count1, err_count3;
  logic        err_valid1, err_valid3;
  logic [3:0]  first_err1, first_err3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Function under test: ab + cd
  assign resp1[0] = (stim1[3] & stim1[2]) | (stim1[1] & stim1[0]);
  assign resp3[0] = (stim3[3] & stim3[2]) | (stim3[1] & stim3[0]);

  truth_table_sweeper #(.N_IN(4), .N_OUT(1), .DWELL(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start1),
    .abort         (abort),
    .expected      (expected),
    .stim          (stim1),
    .resp          (resp1),
    .busy          (busy1),
    .done          (done1),
    .captured      (captured1),
    .err_count     (err_count1),
    .err_valid     (err_valid1),
    .first_err_idx (first_err1)
  );

  truth_table_sweeper #(.N_IN(4), .N_OUT(1), .DWELL(3)) u_dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start3),
    .abort         (abort),
    .expected      (expected),
    .stim          (stim3),
    .resp          (resp3),
    .busy          (busy3),
    .done          (done3),
    .captured      (captured3),
    .err_count     (err_count3),
    .err_valid     (err_valid3),
    .first_err_idx (first_err3)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one sweep and watches busy/stim/done for a bounded number of cycles.
  task automatic sweep(input int dw, input logic [15:0] exp_tbl, input string tag,
                       input bit restart, input bit with_abort);
    int busy_cyc;
    int walk_bad;
    int done_cnt;
    logic b, d;
    logic [3:0] s;
    busy_cyc = 0;
    walk_bad = 0;
    done_cnt = 0;
    expected = exp_tbl;
    if (dw == 1) start1 = 1'b1;
    else start3 = 1'b1;
    abort = with_abort;
    step();
    start1 = 1'b0;
    start3 = 1'b0;
    abort  = 1'b0;
    for (int c = 0; c < 16*dw + 20; c++) begin
      b = (dw == 1) ? busy1 : busy3;
      d = (dw == 1) ? done1 : done3;
      s = (dw == 1) ? stim1 : stim3;
      if (b) begin
        if (s !== 4'(busy_cyc / dw)) walk_bad++;
        busy_cyc++;
      end else if (s !== 4'd0) begin
        walk_bad++;
      end
      if (d) done_cnt++;
      if (restart && c == 10) start3 = 1'b1;
      step();
      start3 = 1'b0;
    end
    chk_val({tag, ".busy_cycles"}, busy_cyc, 16*dw);
    chk_val({tag, ".stim_walk_errs"}, walk_bad, 0);
    chk_val({tag, ".done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; abort = 1'b0; start1 = 1'b0; start3 = 1'b0; expected = '0;
    repeat (3) step();
    chk_val("rst.busy", busy1, 0);
    chk_val("rst.done", done1, 0);
    chk_val("rst.stim", stim1, 0);
    chk_val("rst.captured", captured1, 0);
    chk_val("rst.err_count", err_count1, 0);
    chk_val("rst.err_valid", err_valid1, 0);
    chk_val("rst.first_err", first_err1, 0);
    rst_n = 1'b1;
    step();

    // Scenario 1: exact match
    sweep(1, 16'hF888, "s1", 1'b0, 1'b0);
    chk_val("s1.captured", captured1, 32'hF888);
    chk_val("s1.err_count", err_count1, 0);
    chk_val("s1.err_valid", err_valid1, 0);
    chk_val("s1.first_err", first_err1, 0);

    // Scenario 2: single mismatch at vector 0; abort alongside start is ignored
    sweep(1, 16'hF889, "s2", 1'b0, 1'b1);
    chk_val("s2.captured", captured1, 32'hF888);
    chk_val("s2.err_count", err_count1, 1);
    chk_val("s2.err_valid", err_valid1, 1);
    chk_val("s2.first_err", first_err1, 0);

    // Scenario 3: all-zero expectation, seven minterms mismatch
    sweep(1, 16'h0000, "s3", 1'b0, 1'b0);
    chk_val("s3.err_count", err_count1, 7);
    chk_val("s3.err_valid", err_valid1, 1);
    chk_val("s3.first_err", first_err1, 3);

    // Scenario 4: abort while vector 5 is driven
    expected = 16'hF888;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n < 20 && stim1 !== 4'd5; n++) step();
    chk_val("s4.stim_at_abort", stim1, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_val("s4.busy", busy1, 0);
    chk_val("s4.done", done1, 0);
    chk_val("s4.captured", captured1, 32'h0008);
    chk_val("s4.err_count", err_count1, 0);
    chk_val("s4.err_valid", err_valid1, 0);
    step();
    chk_val("s4.done_later", done1, 0);
    chk_val("s4.captured_held", captured1, 32'h0008);
    chk_val("s4.stim_idle", stim1, 0);

    // Scenario 5: DWELL=3 with a start re-pulse mid-sweep
    sweep(3, 16'hF888, "s5", 1'b1, 1'b0);
    chk_val("s5.captured", captured3, 32'hF888);
    chk_val("s5.err_count", err_count3, 0);
    chk_val("s5.err_valid", err_valid3, 0);

    // Scenario 6: asynchronous reset at vector 9, then a clean sweep
    expected = 16'h0000;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n < 20 && stim1 !== 4'd9; n++) step();
    chk_val("s6.stim_before_rst", stim1, 9);
    chk_val("s6.err_before_rst", err_count1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_val("s6.rst_stim", stim1, 0);
    chk_val("s6.rst_busy", busy1, 0);
    chk_val("s6.rst_captured", captured1, 0);
    chk_val("s6.rst_err_count", err_count1, 0);
    chk_val("s6.rst_err_valid", err_valid1, 0);
    chk_val("s6.rst_first_err", first_err1, 0);
    step();
    rst_n = 1'b1;
    step();
    sweep(1, 16'hF888, "s6", 1'b0, 1'b0);
    chk_val("s6.captured", captured1, 32'hF888);
    chk_val("s6.err_count", err_count1, 0);
    chk_val("s6.err_valid", err_valid1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
